hazard_stall_ctrl: RTL and testbench

Decode-stage hazard and stall controller for the 5-stage RISC-V pipeline. It covers the cases that operand forwarding cannot: load-use dependencies, data-memory wait states and control-flow flushes. It drives the write-enable, bubble and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It also records memory-wait duration and flags a stuck memory.

---
 rtl/hazard_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard/stall controller: load-use bubbles, data-memory wait freeze, branch flush, stuck-memory timeout.
// Optional performance counters (Stall_Cycles, Bubble_Count) are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs1,
  input  logic [4:0]       ID_Rs2,
  input  logic             ID_Uses_Rs1,
  input  logic             ID_Uses_Rs2,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_Branch_Taken,
  input  logic             EX_MEM_MemReq,
  input  logic             Dmem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Stall_All,
  output logic             Mem_Timeout,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [CNT_W-1:0] Bubble_Count,
`endif
  output logic             Dbg_State
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TO_VAL  = WCNT_W'(TIMEOUT);
  localparam logic [WCNT_W-1:0] CNT_ONE = WCNT_W'(1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              load_use, mem_wait, freeze;

  // Once the memory is declared stuck the pipeline stays frozen until reset.
  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
               ((ID_Uses_Rs1 && (ID_EX_Rd == ID_Rs1)) ||
                (ID_Uses_Rs2 && (ID_EX_Rd == ID_Rs2)));
    mem_wait = EX_MEM_MemReq && !Dmem_Ready;
    freeze   = mem_wait || timeout_q;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN:      if (freeze)  state_d = MEM_WAIT;
      MEM_WAIT: if (!freeze) state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (mem_wait) begin
      if (wait_cnt_q != TO_VAL) wait_cnt_d = wait_cnt_q + CNT_ONE;
    end else if (!freeze) begin
      wait_cnt_d = '0;
    end
    if (wait_cnt_d == TO_VAL) timeout_d = 1'b1;
  end

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Stall_All    = 1'b0;
    if (!rst_n) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (freeze) begin
      // A taken branch sits frozen in EX and flushes once the wait ends.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      Stall_All   = 1'b1;
    end else if (EX_Branch_Taken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (load_use) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Mem_Timeout = timeout_q;
  assign Dbg_State   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, bubble_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
    end else begin
      if (Stall_All || !PC_Write) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (ID_EX_Bubble)           bubble_count_q <= bubble_count_q + CNT_W'(1);
    end
  end

  assign Stall_Cycles = stall_cycles_q;
  assign Bubble_Count = bubble_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: vector table, multi-cycle corner sequences, then random traffic against a rule-based model.
module tb_hazard_stall_ctrl;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, id_ex_rd;
  logic id_uses_rs1, id_uses_rs2, id_ex_memread, ex_branch_taken, ex_mem_memreq, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_all, mem_timeout, dbg_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, bubble_count;
`endif

  hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs1(id_rs1), .ID_Rs2(id_rs2), .ID_Uses_Rs1(id_uses_rs1), .ID_Uses_Rs2(id_uses_rs2),
    .ID_EX_Rd(id_ex_rd), .ID_EX_MemRead(id_ex_memread), .EX_Branch_Taken(ex_branch_taken),
    .EX_MEM_MemReq(ex_mem_memreq), .Dmem_Ready(dmem_ready),
    .PC_Write(pc_write), .IF_ID_Write(if_id_write), .IF_ID_Flush(if_id_flush),
    .ID_EX_Bubble(id_ex_bubble), .Stall_All(stall_all), .Mem_Timeout(mem_timeout),
`ifdef HAZARD_PERF_CNT_EN
    .Stall_Cycles(stall_cycles), .Bubble_Count(bubble_count),
`endif
    .Dbg_State(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state: consecutive wait cycles, sticky timeout, "frozen" flag
  int   m_wait = 0;
  logic m_to = 1'b0;
  logic m_st = 1'b0;
  int   m_stall_cyc = 0;
  int   m_bub_cnt = 0;

  logic [4:0] dut_ctrl;
  assign dut_ctrl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_all};

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, mreq, rdy;
    logic [4:0] exp; // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Stall_All}
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Priority list expressed directly: reset, memory freeze, branch flush, load-use bubble, normal.
  function automatic logic [4:0] ref_ctrl(input logic rst, input logic to);
    logic hazard;
    hazard = id_ex_memread && (id_ex_rd != 0) &&
             ((id_uses_rs1 && id_ex_rd == id_rs1) || (id_uses_rs2 && id_ex_rd == id_rs2));
    if (!rst)                                       return 5'b00110;
    if ((ex_mem_memreq && !dmem_ready) || to)       return 5'b00001;
    if (ex_branch_taken)                            return 5'b11110;
    if (hazard)                                     return 5'b00010;
    return 5'b11000;
  endfunction

  task automatic set_in(input logic [4:0] rs1, rs2, rd, input logic u1, u2, mr, br, mreq, rdy);
    id_rs1 = rs1; id_rs2 = rs2; id_ex_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_ex_memread = mr;
    ex_branch_taken = br; ex_mem_memreq = mreq; dmem_ready = rdy;
  endtask

  task automatic set_idle();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Advance one edge and update the model from the inputs present at that edge.
  task automatic tick();
    logic [4:0] c;
    logic mw;
    c  = ref_ctrl(rst_n, m_to);
    mw = ex_mem_memreq && !dmem_ready;
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_to = 1'b0; m_st = 1'b0; m_stall_cyc = 0; m_bub_cnt = 0;
    end else begin
      if (c[0] || !c[4]) m_stall_cyc++;
      if (c[1]) m_bub_cnt++;
      if (mw) begin
        if (m_wait < TIMEOUT) m_wait++;
        if (m_wait == TIMEOUT) m_to = 1'b1;
      end
      m_st = mw || m_to;
      if (!m_st) m_wait = 0;
    end
    #1;
  endtask

  task automatic check_model(input string name);
    chk({name, " ctrl"}, 32'(dut_ctrl), 32'(ref_ctrl(rst_n, m_to)));
    chk({name, " timeout"}, 32'(mem_timeout), 32'(m_to));
    chk({name, " state"}, 32'(dbg_state), 32'(m_st));
`ifdef HAZARD_PERF_CNT_EN
    chk({name, " stall_cnt"}, stall_cycles, 32'(m_stall_cyc));
    chk({name, " bubble_cnt"}, bubble_count, 32'(m_bub_cnt));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    //                 name            rs1 rs2 rd  u1 u2 mr br mq rdy  exp
    tbl[0]  = '{"lw_x1_add",          5'd1, 5'd2, 5'd1, 1, 1, 1, 0, 0, 1, 5'b00010};
    tbl[1]  = '{"load_x0",            5'd0, 5'd2, 5'd0, 1, 1, 1, 0, 0, 1, 5'b11000};
    tbl[2]  = '{"rs2_unused",         5'd3, 5'd5, 5'd5, 1, 0, 1, 0, 0, 1, 5'b11000};
    tbl[3]  = '{"rs2_hazard",         5'd3, 5'd5, 5'd5, 0, 1, 1, 0, 0, 1, 5'b00010};
    tbl[4]  = '{"no_memread",         5'd7, 5'd7, 5'd7, 1, 1, 0, 0, 0, 1, 5'b11000};
    tbl[5]  = '{"branch_loaduse",     5'd1, 5'd2, 5'd1, 1, 1, 1, 1, 0, 1, 5'b11110};
    tbl[6]  = '{"branch_only",        5'd4, 5'd6, 5'd9, 1, 1, 0, 1, 0, 1, 5'b11110};
    tbl[7]  = '{"mem_ready",          5'd4, 5'd6, 5'd9, 1, 1, 0, 0, 1, 1, 5'b11000};
    tbl[8]  = '{"ready_branch_lu",    5'd8, 5'd8, 5'd8, 1, 1, 1, 1, 1, 1, 5'b11110};
    tbl[9]  = '{"mem_wait",           5'd4, 5'd6, 5'd9, 1, 1, 0, 0, 1, 0, 5'b00001};
    tbl[10] = '{"wait_branch_lu",     5'd1, 5'd2, 5'd1, 1, 1, 1, 1, 1, 0, 5'b00001};
    tbl[11] = '{"rdy_low_no_req",     5'd1, 5'd2, 5'd1, 0, 0, 1, 0, 0, 0, 5'b11000};

    rst_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctrl", 32'(dut_ctrl), 32'b00110);
    chk("reset timeout", 32'(mem_timeout), 32'd0);
    chk("reset state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2, tbl[i].mr,
             tbl[i].br, tbl[i].mreq, tbl[i].rdy);
      #2;
      chk(tbl[i].name, 32'(dut_ctrl), 32'(tbl[i].exp));
      tick();
    end
    set_idle();
    tick();

    // load-use costs one bubble; next cycle the load is in MEM and the add is in EX
    set_in(5'd1, 5'd2, 5'd1, 1, 1, 1, 0, 0, 1);
    #2 chk("lu_bubble", 32'(dut_ctrl), 32'b00010);
    tick();
    set_in(5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 0, 1);
    #2 chk("lu_after", 32'(dut_ctrl), 32'b11000);
    tick();

    // three wait cycles, then completion
    set_in(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #2 chk("wait3 stall", 32'(stall_all), 32'd1);
      tick();
      chk("wait3 state", 32'(dbg_state), 32'd1);
    end
    dmem_ready = 1'b1;
    #2 chk("wait3 done", 32'(dut_ctrl), 32'b11000);
    tick();
    chk("wait3 run", 32'(dbg_state), 32'd0);

    // branch held through a memory wait, flushes when the wait ends
    set_in(5'd1, 5'd2, 5'd1, 1, 1, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #2 chk("br_wait", 32'(dut_ctrl), 32'b00001);
      tick();
    end
    dmem_ready = 1'b1;
    #2 chk("br_wait_end", 32'(dut_ctrl), 32'b11110);
    tick();

    // Dmem_Ready returns together with a fresh load-use: bubble that same cycle
    set_in(5'd4, 5'd6, 5'd9, 0, 0, 0, 0, 1, 0);
    tick();
    set_in(5'd6, 5'd4, 5'd6, 1, 0, 1, 0, 1, 1);
    #2 chk("ready_lu", 32'(dut_ctrl), 32'b00010);
    tick();

    // stuck memory: timeout on the 64th edge, sticky, cleared by reset
    do_reset();
    set_in(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (i == TIMEOUT - 1) chk("to_before", 32'(mem_timeout), 32'd0);
    end
    chk("to_set", 32'(mem_timeout), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    chk("to_stall_cycles", stall_cycles, 32'd64);
`endif
    repeat (3) tick();
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    set_idle();
    tick();
    chk("to_sticky_ready", 32'(mem_timeout), 32'd1);
    rst_n = 1'b0;
    #2 chk("rst_ctrl", 32'(dut_ctrl), 32'b00110);
    tick();
    rst_n = 1'b1;
    chk("to_cleared", 32'(mem_timeout), 32'd0);
    chk("to_rst_state", 32'(dbg_state), 32'd0);

    // reset in the middle of a wait
    set_in(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midwait_state", 32'(dbg_state), 32'd0);
    chk("midwait_timeout", 32'(mem_timeout), 32'd0);
    set_idle();
    #2 check_model("post_midwait");
    tick();

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
             1'($urandom), ($urandom_range(0, 3) != 0));
      #2 check_model("rand");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
